// File: rtl/cpu_isa_pkg.sv
// ISA constants, instruction field positions, decode helper and FSM encodings
// shared by the operand issue stage and its testbench.
package cpu_isa_pkg;

  localparam int DW   = 16;
  localparam int NREG = 8;
  localparam int RW   = 3;

  localparam int RD_HI  = 13;
  localparam int RD_LO  = 11;
  localparam int RS1_HI = 10;
  localparam int RS1_LO = 8;
  localparam int RS2_HI = 7;
  localparam int RS2_LO = 5;

  typedef enum logic [0:0] {
    ST_ISSUE   = 1'b0,
    ST_WAIT_BR = 1'b1
  } state_e;

  typedef struct packed {
    logic legal;
    logic use1;
    logic use2;
    logic wen;
    logic br;
  } dec_t;

  // Priority decode: the first matching pattern wins, no match is illegal.
  function automatic dec_t decode(input logic [DW-1:0] ir);
    dec_t d;
    d = '0;
    casez (ir)
      16'b00000_??????_00000: begin d.legal = 1'b1; d.use1 = 1'b1; d.use2 = 1'b1; end
      16'b00_???_???_00000001: begin d.legal = 1'b1; d.use1 = 1'b1; d.wen = 1'b1; end
      16'b00_???_???_???_00010,
      16'b00_???_???_???_00011: begin
        d.legal = 1'b1; d.use1 = 1'b1; d.use2 = 1'b1; d.wen = 1'b1;
      end
      16'b01_???_000_????????: begin d.legal = 1'b1; d.wen = 1'b1; end
      16'b10_000_000_????????: begin d.legal = 1'b1; d.br = 1'b1; end
      16'b10001_???_????????,
      16'b10010_???_????????: begin d.legal = 1'b1; d.use1 = 1'b1; d.br = 1'b1; end
      16'b11_???_???_???_?????: begin
        d.legal = 1'b1; d.use1 = 1'b1; d.use2 = 1'b1; d.br = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/operand_issue_if.sv
// Bundle of fetch, writeback, branch-completion and ALU-issue signals around
// the operand issue stage; slave is the stage, master is its environment.
interface operand_issue_if;
  import cpu_isa_pkg::*;

  logic          if_valid;
  logic          if_ready;
  logic [DW-1:0] if_ir;
  logic [DW-1:0] if_pc;
  logic          wb_en;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          br_done;
  logic          ex_ready;
  logic          load;
  logic [DW-1:0] ir;
  logic [DW-1:0] pc;
  logic [DW-1:0] sr1;
  logic [DW-1:0] sr2;
  logic [RW-1:0] ex_rd;
  logic          ex_wen;
  logic          illegal;

  modport slave (
    input  if_valid, if_ir, if_pc, wb_en, wb_rd, wb_data, br_done, ex_ready,
    output if_ready, load, ir, pc, sr1, sr2, ex_rd, ex_wen, illegal
  );

  modport master (
    output if_valid, if_ir, if_pc, wb_en, wb_rd, wb_data, br_done, ex_ready,
    input  if_ready, load, ir, pc, sr1, sr2, ex_rd, ex_wen, illegal
  );

endinterface

// File: rtl/regfile_8x16.sv
// 8x16 register file: two asynchronous read ports, one synchronous write port.
// A read of the register being written this cycle returns the write data.
module regfile_8x16
  import cpu_isa_pkg::*;
(
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          i_we,
  input  logic [RW-1:0] i_wa,
  input  logic [DW-1:0] i_wd,
  input  logic [RW-1:0] i_ra1,
  input  logic [RW-1:0] i_ra2,
  output logic [DW-1:0] o_rd1,
  output logic [DW-1:0] o_rd2
);

  logic [DW-1:0] r_mem [NREG];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_we && (i_wa == i_ra1)) ? i_wd : r_mem[i_ra1];
  assign o_rd2 = (i_we && (i_wa == i_ra2)) ? i_wd : r_mem[i_ra2];

endmodule

// File: rtl/operand_issue.sv
// Decode / register-read stage: RAW scoreboard, branch wait FSM and registered
// operand issue towards the ALU.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   ST_ISSUE   | accepting instructions when downstream ready, no hazard
//   ST_WAIT_BR | branch issued, fetch blocked until br_done
module operand_issue
  import cpu_isa_pkg::*;
(
  input logic         CLK,
  input logic         RSTN,
  operand_issue_if.slave io
);

  state_e          r_state;
  state_e          w_state_nxt;
  dec_t            w_dec;
  logic [RW-1:0]   w_rs1;
  logic [RW-1:0]   w_rs2;
  logic [RW-1:0]   w_rd;
  logic [DW-1:0]   w_rd1;
  logic [DW-1:0]   w_rd2;
  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_pend_nxt;
  logic            w_hz1;
  logic            w_hz2;
  logic            w_in_issue;
  logic            w_ready;
  logic            w_accept;
  logic            w_issue;

  logic            r_load;
  logic            r_illegal;
  logic            r_ex_wen;
  logic [RW-1:0]   r_ex_rd;
  logic [DW-1:0]   r_ir;
  logic [DW-1:0]   r_pc;
  logic [DW-1:0]   r_sr1;
  logic [DW-1:0]   r_sr2;

  assign w_dec = decode(io.if_ir);
  assign w_rs1 = io.if_ir[RS1_HI:RS1_LO];
  assign w_rs2 = io.if_ir[RS2_HI:RS2_LO];
  assign w_rd  = io.if_ir[RD_HI:RD_LO];

  regfile_8x16 u_rf (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .i_we  (io.wb_en),
    .i_wa  (io.wb_rd),
    .i_wd  (io.wb_data),
    .i_ra1 (w_rs1),
    .i_ra2 (w_rs2),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2)
  );

  // A pending source resolves in the same cycle its writeback arrives (bypass).
  assign w_hz1 = w_dec.use1 && r_pend[w_rs1] && !(io.wb_en && (io.wb_rd == w_rs1));
  assign w_hz2 = w_dec.use2 && r_pend[w_rs2] && !(io.wb_en && (io.wb_rd == w_rs2));

  assign w_ready  = w_in_issue && io.ex_ready && !(w_hz1 || w_hz2);
  assign w_accept = io.if_valid && w_ready;
  assign w_issue  = w_accept && w_dec.legal;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) r_state <= ST_ISSUE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ISSUE:   if (w_issue && w_dec.br) w_state_nxt = ST_WAIT_BR;
      ST_WAIT_BR: if (io.br_done)          w_state_nxt = ST_ISSUE;
      default:                             w_state_nxt = ST_ISSUE;
    endcase
  end

  always_comb begin
    w_in_issue = (r_state == ST_ISSUE);
  end

  // Set after clear so a same-cycle issue and writeback leaves the bit set.
  always_comb begin
    w_pend_nxt = r_pend;
    if (io.wb_en)             w_pend_nxt[io.wb_rd] = 1'b0;
    if (w_issue && w_dec.wen) w_pend_nxt[w_rd]     = 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) r_pend <= '0;
    else       r_pend <= w_pend_nxt;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_load    <= 1'b0;
      r_illegal <= 1'b0;
      r_ex_wen  <= 1'b0;
      r_ex_rd   <= '0;
      r_ir      <= '0;
      r_pc      <= '0;
      r_sr1     <= '0;
      r_sr2     <= '0;
    end else begin
      r_load    <= w_issue;
      r_illegal <= w_accept && !w_dec.legal;
      if (w_issue) begin
        r_ir     <= io.if_ir;
        r_pc     <= io.if_pc;
        r_sr1    <= w_rd1;
        r_sr2    <= w_rd2;
        r_ex_rd  <= w_rd;
        r_ex_wen <= w_dec.wen;
      end
    end
  end

  assign io.if_ready = w_ready;
  assign io.load     = r_load;
  assign io.illegal  = r_illegal;
  assign io.ir       = r_ir;
  assign io.pc       = r_pc;
  assign io.sr1      = r_sr1;
  assign io.sr2      = r_sr2;
  assign io.ex_rd    = r_ex_rd;
  assign io.ex_wen   = r_ex_wen;

endmodule

// File: tb/tb_operand_issue.sv
// Testbench for operand_issue: directed scenarios followed by randomized
// traffic checked against a cycle-level reference model.
module tb_operand_issue;
  import cpu_isa_pkg::*;

  logic CLK = 1'b0;
  logic RSTN = 1'b0;
  always #5 CLK = ~CLK;

  operand_issue_if bus ();

  operand_issue dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .io   (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [15:0] m_regs [8];
  bit          m_pend [8];
  bit          m_wait;
  bit          m_load, m_ill, m_wen;
  logic [15:0] m_ir, m_pc, m_sr1, m_sr2;
  logic [2:0]  m_rd;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_idle();
    bus.if_valid = 1'b0; bus.if_ir = '0; bus.if_pc = '0;
    bus.wb_en = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.br_done = 1'b0; bus.ex_ready = 1'b1;
  endtask

  task automatic wb(input logic [2:0] rd, input logic [15:0] data);
    bus.wb_en = 1'b1; bus.wb_rd = rd; bus.wb_data = data;
    tick();
    bus.wb_en = 1'b0;
  endtask

  // Reference decode by instruction class, first match wins.
  function automatic void ref_decode(input logic [15:0] w, output bit legal, output bit u1,
                                     output bit u2, output bit wr, output bit br);
    legal = 1; u1 = 0; u2 = 0; wr = 0; br = 0;
    if (w[15:11] == 5'd0 && w[4:0] == 5'd0) begin u1 = 1; u2 = 1; end
    else if (w[15:14] == 2'd0 && w[7:0] == 8'h01) begin u1 = 1; wr = 1; end
    else if (w[15:14] == 2'd0 && (w[4:0] == 5'd2 || w[4:0] == 5'd3)) begin u1 = 1; u2 = 1; wr = 1; end
    else if (w[15:14] == 2'b01 && w[10:8] == 3'd0) wr = 1;
    else if (w[15:8] == 8'h80) br = 1;
    else if (w[15:11] == 5'b10001 || w[15:11] == 5'b10010) begin u1 = 1; br = 1; end
    else if (w[15:14] == 2'b11) begin u1 = 1; u2 = 1; br = 1; end
    else legal = 0;
  endfunction

  function automatic logic [15:0] rand_instr();
    logic [2:0] a, b, c;
    logic [7:0] imm;
    a = 3'($urandom_range(0, 7)); b = 3'($urandom_range(0, 7)); c = 3'($urandom_range(0, 7));
    imm = 8'($urandom_range(0, 255));
    case ($urandom_range(0, 10))
      0:       return {5'b00000, b, c, 5'b00000};
      1:       return {2'b00, a, b, 8'h01};
      2:       return {2'b00, a, b, c, 5'b00010};
      3:       return {2'b00, a, b, c, 5'b00011};
      4:       return {2'b01, a, 3'b000, imm};
      5:       return {8'h80, imm};
      6:       return {5'b10001, b, imm};
      7:       return {5'b10010, b, imm};
      8:       return {2'b11, a, b, c, imm[4:0]};
      9:       return {2'b01, a, b, imm};
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    drive_idle();
    RSTN = 1'b0;
    tick(); tick();
    tests++;
    if ({bus.load, bus.illegal, bus.ex_wen, bus.ex_rd, bus.ir, bus.pc, bus.sr1, bus.sr2} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got load=%0b ill=%0b wen=%0b rd=%0d ir=%h pc=%h sr1=%h sr2=%h want all 0",
               bus.load, bus.illegal, bus.ex_wen, bus.ex_rd, bus.ir, bus.pc, bus.sr1, bus.sr2);
    end
    tests++;
    if (bus.if_ready !== 1'b1) begin fails++; $display("FAIL reset_if_ready got %b want 1", bus.if_ready); end
    RSTN = 1'b1;
    tick();
  endtask

  task automatic test_issue_add();
    wb(3'd1, 16'd5);
    wb(3'd2, 16'd7);
    bus.if_valid = 1'b1; bus.if_ir = 16'h1942; bus.if_pc = 16'h0100;
    #1;
    tests++;
    if (bus.if_ready !== 1'b1) begin fails++; $display("FAIL add_if_ready got %b want 1", bus.if_ready); end
    tick();
    bus.if_valid = 1'b0;
    tests++;
    if ({bus.load, bus.sr1, bus.sr2, bus.ex_rd, bus.ex_wen, bus.ir, bus.pc} !== {1'b1, 16'd5, 16'd7, 3'd3, 1'b1, 16'h1942, 16'h0100}) begin
      fails++;
      $display("FAIL add_issue got load=%b sr1=%0d sr2=%0d rd=%0d wen=%b ir=%h pc=%h want 1 5 7 3 1 1942 0100",
               bus.load, bus.sr1, bus.sr2, bus.ex_rd, bus.ex_wen, bus.ir, bus.pc);
    end
    tick();
    tests++;
    if (bus.load !== 1'b0) begin fails++; $display("FAIL add_load_pulse got %b want 0", bus.load); end
  endtask

  task automatic test_raw_bypass();
    bus.if_valid = 1'b1; bus.if_ir = 16'h1942; bus.if_pc = 16'h0102;
    tick();
    bus.if_ir = 16'h2322; bus.if_pc = 16'h0104;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (bus.if_ready !== 1'b0) begin fails++; $display("FAIL raw_stall cycle %0d if_ready got %b want 0", i, bus.if_ready); end
      tick();
    end
    bus.wb_en = 1'b1; bus.wb_rd = 3'd3; bus.wb_data = 16'd12;
    #1;
    tests++;
    if (bus.if_ready !== 1'b1) begin fails++; $display("FAIL raw_bypass_ready got %b want 1", bus.if_ready); end
    tick();
    bus.wb_en = 1'b0; bus.if_valid = 1'b0;
    tests++;
    if ({bus.load, bus.sr1, bus.sr2, bus.ex_rd, bus.ir} !== {1'b1, 16'd12, 16'd5, 3'd4, 16'h2322}) begin
      fails++;
      $display("FAIL raw_bypass_issue got load=%b sr1=%0d sr2=%0d rd=%0d ir=%h want 1 12 5 4 2322",
               bus.load, bus.sr1, bus.sr2, bus.ex_rd, bus.ir);
    end
    wb(3'd4, 16'd1);
  endtask

  task automatic test_branch();
    bus.br_done = 1'b1;
    tick();
    bus.br_done = 1'b0;
    bus.if_valid = 1'b1; bus.if_ir = 16'h9104; bus.if_pc = 16'h0200;
    #1;
    tests++;
    if (bus.if_ready !== 1'b1) begin fails++; $display("FAIL br_ignored_done if_ready got %b want 1", bus.if_ready); end
    tick();
    tests++;
    if ({bus.load, bus.ir, bus.sr1, bus.ex_wen} !== {1'b1, 16'h9104, 16'd5, 1'b0}) begin
      fails++;
      $display("FAIL br_issue got load=%b ir=%h sr1=%0d wen=%b want 1 9104 5 0", bus.load, bus.ir, bus.sr1, bus.ex_wen);
    end
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (bus.if_ready !== 1'b0) begin fails++; $display("FAIL br_wait cycle %0d if_ready got %b want 0", i, bus.if_ready); end
      tick();
    end
    tests++;
    if (bus.load !== 1'b0) begin fails++; $display("FAIL br_wait_load got %b want 0", bus.load); end
    bus.br_done = 1'b1;
    #1;
    tests++;
    if (bus.if_ready !== 1'b0) begin fails++; $display("FAIL br_done_cycle if_ready got %b want 0", bus.if_ready); end
    tick();
    bus.br_done = 1'b0; bus.if_valid = 1'b0;
    tests++;
    if (bus.if_ready !== 1'b1) begin fails++; $display("FAIL br_release if_ready got %b want 1", bus.if_ready); end
  endtask

  task automatic test_stall();
    bus.ex_ready = 1'b0; bus.if_valid = 1'b1; bus.if_ir = 16'h2942; bus.if_pc = 16'h0300;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (bus.if_ready !== 1'b0) begin fails++; $display("FAIL stall_ready cycle %0d got %b want 0", i, bus.if_ready); end
      tick();
      tests++;
      if ({bus.load, bus.ir, bus.sr1, bus.sr2} !== {1'b0, 16'h9104, 16'd5, 16'd0}) begin
        fails++;
        $display("FAIL stall_hold cycle %0d got load=%b ir=%h sr1=%0d sr2=%0d want 0 9104 5 0",
                 i, bus.load, bus.ir, bus.sr1, bus.sr2);
      end
    end
    bus.ex_ready = 1'b1;
    #1;
    tests++;
    if (bus.if_ready !== 1'b1) begin fails++; $display("FAIL stall_release_ready got %b want 1", bus.if_ready); end
    tick();
    bus.if_valid = 1'b0;
    tests++;
    if ({bus.load, bus.ir, bus.pc, bus.sr1, bus.sr2, bus.ex_rd} !== {1'b1, 16'h2942, 16'h0300, 16'd5, 16'd7, 3'd5}) begin
      fails++;
      $display("FAIL stall_issue got load=%b ir=%h pc=%h sr1=%0d sr2=%0d rd=%0d want 1 2942 0300 5 7 5",
               bus.load, bus.ir, bus.pc, bus.sr1, bus.sr2, bus.ex_rd);
    end
    wb(3'd5, 16'h0055);
  endtask

  task automatic test_illegal();
    bus.if_valid = 1'b1; bus.if_ir = 16'h0004; bus.if_pc = 16'h0400;
    #1;
    tests++;
    if (bus.if_ready !== 1'b1) begin fails++; $display("FAIL ill_ready got %b want 1", bus.if_ready); end
    tick();
    bus.if_valid = 1'b0;
    tests++;
    if ({bus.illegal, bus.load, bus.ir, bus.pc} !== {1'b1, 1'b0, 16'h2942, 16'h0300}) begin
      fails++;
      $display("FAIL ill_pulse got ill=%b load=%b ir=%h pc=%h want 1 0 2942 0300", bus.illegal, bus.load, bus.ir, bus.pc);
    end
    bus.if_ir = 16'h0000;
    tick();
    tests++;
    if ({bus.illegal, bus.if_ready} !== 2'b01) begin
      fails++;
      $display("FAIL ill_after got ill=%b if_ready=%b want 0 1", bus.illegal, bus.if_ready);
    end
  endtask

  task automatic test_reset_mid();
    bus.if_valid = 1'b1; bus.if_ir = 16'h1942; bus.if_pc = 16'h0500;
    tick();
    bus.if_ir = 16'h8005; bus.if_pc = 16'h0502;
    tick();
    bus.if_valid = 1'b0;
    tests++;
    if ({bus.load, bus.ir, bus.if_ready} !== {1'b1, 16'h8005, 1'b0}) begin
      fails++;
      $display("FAIL rst_mid_setup got load=%b ir=%h if_ready=%b want 1 8005 0", bus.load, bus.ir, bus.if_ready);
    end
    RSTN = 1'b0;
    #1;
    tests++;
    if ({bus.load, bus.illegal, bus.ex_wen, bus.ex_rd, bus.ir, bus.pc, bus.sr1, bus.sr2} !== '0) begin
      fails++;
      $display("FAIL rst_mid_outputs got load=%b wen=%b rd=%0d ir=%h pc=%h sr1=%h sr2=%h want all 0",
               bus.load, bus.ex_wen, bus.ex_rd, bus.ir, bus.pc, bus.sr1, bus.sr2);
    end
    #3;
    RSTN = 1'b1;
    bus.if_valid = 1'b1; bus.if_ir = 16'h2322; bus.if_pc = 16'h0600;
    #1;
    tests++;
    if (bus.if_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_ready got %b want 1", bus.if_ready); end
    tick();
    bus.if_valid = 1'b0;
    tests++;
    if ({bus.load, bus.sr1, bus.sr2} !== {1'b1, 16'd0, 16'd0}) begin
      fails++;
      $display("FAIL rst_mid_regs got load=%b sr1=%h sr2=%h want 1 0 0", bus.load, bus.sr1, bus.sr2);
    end
  endtask

  task automatic test_random();
    bit legal, u1, u2, wr, br, hz, rdy, acc;
    logic [2:0]  s1, s2, rd;
    logic [15:0] v1, v2;
    drive_idle();
    RSTN = 1'b0;
    tick();
    RSTN = 1'b1;
    for (int i = 0; i < 8; i++) begin m_regs[i] = '0; m_pend[i] = 0; end
    m_wait = 0; m_wen = 0; m_rd = '0; m_ir = '0; m_pc = '0; m_sr1 = '0; m_sr2 = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      bus.if_valid = ($urandom_range(0, 3) != 0);
      bus.if_ir    = rand_instr();
      bus.if_pc    = 16'($urandom);
      bus.wb_en    = ($urandom_range(0, 2) == 0);
      bus.wb_rd    = 3'($urandom_range(0, 7));
      bus.wb_data  = 16'($urandom);
      bus.br_done  = ($urandom_range(0, 3) == 0);
      bus.ex_ready = ($urandom_range(0, 4) != 0);
      #1;
      ref_decode(bus.if_ir, legal, u1, u2, wr, br);
      s1 = bus.if_ir[10:8]; s2 = bus.if_ir[7:5]; rd = bus.if_ir[13:11];
      hz = (u1 && m_pend[s1] && !(bus.wb_en && bus.wb_rd == s1)) ||
           (u2 && m_pend[s2] && !(bus.wb_en && bus.wb_rd == s2));
      rdy = !m_wait && bus.ex_ready && !hz;
      tests++;
      if (bus.if_ready !== rdy) begin fails++; $display("FAIL rand_if_ready cyc %0d got %b want %b", cyc, bus.if_ready, rdy); end
      acc = bus.if_valid && rdy;
      v1 = (bus.wb_en && bus.wb_rd == s1) ? bus.wb_data : m_regs[s1];
      v2 = (bus.wb_en && bus.wb_rd == s2) ? bus.wb_data : m_regs[s2];
      m_load = acc && legal;
      m_ill  = acc && !legal;
      if (m_load) begin
        m_ir = bus.if_ir; m_pc = bus.if_pc; m_sr1 = v1; m_sr2 = v2; m_rd = rd; m_wen = wr;
      end
      if (bus.wb_en) begin m_regs[bus.wb_rd] = bus.wb_data; m_pend[bus.wb_rd] = 0; end
      if (m_load && wr) m_pend[rd] = 1;
      if (m_wait) begin
        if (bus.br_done) m_wait = 0;
      end else if (m_load && br) begin
        m_wait = 1;
      end
      tick();
      tests++;
      if ({bus.load, bus.illegal} !== {m_load, m_ill}) begin
        fails++;
        $display("FAIL rand_pulses cyc %0d got load=%b ill=%b want %b %b", cyc, bus.load, bus.illegal, m_load, m_ill);
      end
      tests++;
      if ({bus.ir, bus.pc, bus.sr1, bus.sr2, bus.ex_rd, bus.ex_wen} !== {m_ir, m_pc, m_sr1, m_sr2, m_rd, m_wen}) begin
        fails++;
        $display("FAIL rand_issue cyc %0d got ir=%h pc=%h sr1=%h sr2=%h rd=%0d wen=%b want %h %h %h %h %0d %b",
                 cyc, bus.ir, bus.pc, bus.sr1, bus.sr2, bus.ex_rd, bus.ex_wen,
                 m_ir, m_pc, m_sr1, m_sr2, m_rd, m_wen);
      end
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_issue_add();
    test_raw_bypass();
    test_branch();
    test_stall();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
